// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code constants, op encoding and conversion helpers
package gray_pkg;

  // Supported counter widths; the top level refuses to elaborate outside this range.
  localparam int GRAY_MIN_WIDTH = 2;
  localparam int GRAY_MAX_WIDTH = 16;

  // Generic word wide enough for any supported width; narrower values are zero-extended.
  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // Per-edge action of the counter after priority resolution (reset is handled in the flops).
  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_LOAD    = 2'd1,
    OP_STEP_UP = 2'd2,
    OP_STEP_DN = 2'd3
  } cnt_op_e;

  // Binary to Gray. Zero-extended inputs produce zero-extended outputs, so any width works.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary as a running XOR from the MSB down. Leading zeros from zero-extension
  // leave the prefix XOR untouched, so the low bits are correct for every narrower width.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    logic       acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational WIDTH-bit Gray to binary converter
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it; a single running
  // accumulator keeps the chain inside one block without a feedback net on bin_o.
  always_comb begin
    logic acc;
    bin_o = '0;
    acc   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - WIDTH-bit up/down Gray counter with load and wrap pulse
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] BIN,
  output logic             WRAP
);

  // Refuse to build a counter outside the supported width range.
  generate
    if (WIDTH < GRAY_MIN_WIDTH || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
      $error("gray_counter_n: WIDTH must lie in 2..16");
    end
  endgenerate

  localparam logic [WIDTH-1:0] CNT_ONES = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] ld_bin;
  cnt_op_e          op;

  // Load value arrives Gray-coded; the counter itself runs in binary.
  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_ld_gray_to_bin (
    .gray_i(D),
    .bin_o (ld_bin)
  );

  // Resolve LD over EN; reset outranks both and is applied directly in the flops.
  always_comb begin
    op = OP_HOLD;
    if (LD) begin
      op = OP_LOAD;
    end else if (EN) begin
      op = UP ? OP_STEP_UP : OP_STEP_DN;
    end
  end

  // Next binary count and wrap detection; wrap only fires when a step crosses the boundary.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    case (op)
      OP_LOAD: begin
        cnt_d = ld_bin;
      end
      OP_STEP_UP: begin
        cnt_d  = cnt_q + CNT_ONE;
        wrap_d = (cnt_q == CNT_ONES);
      end
      OP_STEP_DN: begin
        cnt_d  = cnt_q - CNT_ONE;
        wrap_d = (cnt_q == '0);
      end
      default: begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
      end
    endcase
  end

  // Gray output is encoded from the next count so it registers on the same edge as BIN.
  always_comb begin
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  // Output register bank with synchronous active-high reset.
  always_ff @(posedge C) begin
    if (R) begin
      cnt_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign OUT  = gray_q;
  assign BIN  = cnt_q;
  assign WRAP = wrap_q;

endmodule
